spi_flash_multiload: RTL and testbench

- Parametrised successor to the single-region SPI-flash-to-BRAM loader: copies up to REGIONS independent flash regions into one or more on-chip memories after a single start pulse.
- Issues JEDEC READ (0x03) transactions through the toggle-handshake SPI byte engine.
- Emits one-cycle write strobes with address/data toward cart or BRAM storage, and keeps a running 8-bit checksum.
- Sits between the USB slot logic, the SPI byte engine (chameleon2_spi) and cart memories; drives flash_cs.

---
 rtl/spi_flash_multiload_if.sv | 24 ++
 rtl/spi_flash_multiload.sv | 189 ++++++++++++++++++
 tb/tb_spi_flash_multiload.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_flash_multiload_if.sv
// Bundles the flash-side SPI byte-engine handshake and the memory write port of the multi-region loader.
interface spi_flash_multiload_if #(
    parameter int A_BITS = 14
);
    logic              cs_n;
    logic              spi_req;
    logic              spi_ack;
    logic [7:0]        spi_d;
    logic [7:0]        spi_q;
    logic              wr_strobe;
    logic [A_BITS-1:0] wr_a;
    logic [7:0]        wr_d;
    logic              wr_busy;

    modport master (
        output cs_n, spi_req, spi_d, wr_strobe, wr_a, wr_d,
        input  spi_ack, spi_q, wr_busy
    );

    modport slave (
        input  cs_n, spi_req, spi_d, wr_strobe, wr_a, wr_d,
        output spi_ack, spi_q, wr_busy
    );
endinterface

// File: rtl/spi_flash_multiload.sv
// Copies up to REGIONS flash regions (JEDEC READ 0x03) into on-chip memory after one start pulse.
// States: IDLE wait | NEXT pick region | SELECT cs low | CMD/ADDR2/ADDR1/ADDR0/DATA byte xfer | WRITE strobe | DESELECT cs gap
module spi_flash_multiload #(
    parameter int A_BITS        = 14,
    parameter int LEN_BITS      = 16,
    parameter int REGIONS       = 4,
    parameter int SLOT_SHIFT    = 20,
    parameter int CS_IDLE_TICKS = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        abort,
    input  logic [3:0]                  slot,
    input  logic [REGIONS-1:0]          region_en,
    input  logic [24*REGIONS-1:0]       region_offset,
    input  logic [A_BITS*REGIONS-1:0]   region_dest,
    input  logic [LEN_BITS*REGIONS-1:0] region_len,
    spi_flash_multiload_if.master       bus,
    output logic                        busy,
    output logic                        done,
    output logic                        aborted,
    output logic [2:0]                  region_idx,
    output logic [7:0]                  checksum
);

    typedef enum logic [3:0] {
        S_IDLE, S_SELECT, S_CMD, S_ADDR2, S_ADDR1, S_ADDR0,
        S_DATA, S_WRITE, S_DESELECT, S_NEXT
    } state_t;

    localparam logic [3:0] RIDX_END = 4'(REGIONS);

    state_t              state;
    logic [3:0]          ridx;
    logic [23:0]         flash_addr;
    logic [A_BITS-1:0]   dest;
    logic [LEN_BITS-1:0] remaining;
    logic [7:0]          ticks;
    logic                abort_pend;

    // Descriptors padded to 16 entries so a 4-bit index never selects out of range.
    logic                en_a   [16];
    logic [23:0]         off_a  [16];
    logic [A_BITS-1:0]   dest_a [16];
    logic [LEN_BITS-1:0] len_a  [16];

    for (genvar g = 0; g < 16; g++) begin : g_region
        if (g < REGIONS) begin : g_used
            assign en_a[g]   = region_en[g];
            assign off_a[g]  = region_offset[24*g +: 24];
            assign dest_a[g] = region_dest[A_BITS*g +: A_BITS];
            assign len_a[g]  = region_len[LEN_BITS*g +: LEN_BITS];
        end else begin : g_pad
            assign en_a[g]   = 1'b0;
            assign off_a[g]  = '0;
            assign dest_a[g] = '0;
            assign len_a[g]  = '0;
        end
    end

    logic [23:0] slot_base;
    logic [23:0] region_addr;
    logic        sending;
    logic        byte_wait;

    assign slot_base   = 24'(32'(slot) << SLOT_SHIFT);
    assign region_addr = slot_base + off_a[ridx];
    assign sending     = state inside {S_CMD, S_ADDR2, S_ADDR1, S_ADDR0, S_DATA};
    assign byte_wait   = sending && (bus.spi_ack != bus.spi_req);
    assign region_idx  = ridx[2:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            bus.cs_n      <= 1'b1;
            bus.spi_req   <= 1'b0;
            bus.spi_d     <= 8'h00;
            bus.wr_strobe <= 1'b0;
            bus.wr_a      <= '0;
            bus.wr_d      <= 8'h00;
            busy          <= 1'b0;
            done          <= 1'b0;
            aborted       <= 1'b0;
            checksum      <= 8'h00;
            ridx          <= 4'd0;
            flash_addr    <= '0;
            dest          <= '0;
            remaining     <= '0;
            ticks         <= 8'd0;
            abort_pend    <= 1'b0;
        end else begin
            bus.wr_strobe <= 1'b0;
            if (state == S_IDLE) begin
                abort_pend <= 1'b0;
                if (start) begin
                    state    <= S_NEXT;
                    ridx     <= 4'd0;
                    done     <= 1'b0;
                    aborted  <= 1'b0;
                    checksum <= 8'h00;
                    busy     <= 1'b1;
                end
            end else if ((abort || abort_pend) && !byte_wait) begin
                state      <= S_IDLE;
                bus.cs_n   <= 1'b1;
                busy       <= 1'b0;
                aborted    <= 1'b1;
                done       <= 1'b0;
                abort_pend <= 1'b0;
            end else begin
                // An abort arriving mid-byte is held until the engine acknowledges.
                if (abort) abort_pend <= 1'b1;
                case (state)
                    S_NEXT: begin
                        if (ridx == RIDX_END) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else if (!en_a[ridx] || len_a[ridx] == '0) begin
                            ridx <= ridx + 4'd1;
                        end else begin
                            flash_addr <= region_addr;
                            dest       <= dest_a[ridx];
                            remaining  <= len_a[ridx];
                            bus.cs_n   <= 1'b0;
                            state      <= S_SELECT;
                        end
                    end
                    S_SELECT: begin
                        bus.spi_d   <= 8'h03;
                        bus.spi_req <= ~bus.spi_req;
                        state       <= S_CMD;
                    end
                    S_CMD: if (!byte_wait) begin
                        bus.spi_d   <= flash_addr[23:16];
                        bus.spi_req <= ~bus.spi_req;
                        state       <= S_ADDR2;
                    end
                    S_ADDR2: if (!byte_wait) begin
                        bus.spi_d   <= flash_addr[15:8];
                        bus.spi_req <= ~bus.spi_req;
                        state       <= S_ADDR1;
                    end
                    S_ADDR1: if (!byte_wait) begin
                        bus.spi_d   <= flash_addr[7:0];
                        bus.spi_req <= ~bus.spi_req;
                        state       <= S_ADDR0;
                    end
                    S_ADDR0: if (!byte_wait) begin
                        bus.spi_d   <= 8'h00;
                        bus.spi_req <= ~bus.spi_req;
                        state       <= S_DATA;
                    end
                    S_DATA: if (!byte_wait) begin
                        bus.wr_d <= bus.spi_q;
                        bus.wr_a <= dest;
                        state    <= S_WRITE;
                    end
                    S_WRITE: if (!bus.wr_busy) begin
                        bus.wr_strobe <= 1'b1;
                        checksum      <= checksum + bus.wr_d;
                        dest          <= dest + A_BITS'(1);
                        remaining     <= remaining - LEN_BITS'(1);
                        if (remaining == LEN_BITS'(1)) begin
                            bus.cs_n <= 1'b1;
                            ticks    <= 8'(CS_IDLE_TICKS - 1);
                            state    <= S_DESELECT;
                        end else begin
                            bus.spi_d   <= 8'h00;
                            bus.spi_req <= ~bus.spi_req;
                            state       <= S_DATA;
                        end
                    end
                    S_DESELECT: begin
                        if (ticks == 8'd0) begin
                            ridx  <= ridx + 4'd1;
                            state <= S_NEXT;
                        end else begin
                            ticks <= ticks - 8'd1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_flash_multiload.sv
// Directed bench for spi_flash_multiload with a toggle-handshake SPI engine and flash model.
module tb_spi_flash_multiload;
    localparam int A_BITS   = 14;
    localparam int LEN_BITS = 16;
    localparam int REGIONS  = 4;

    logic                        clk = 1'b0;
    logic                        reset = 1'b1;
    logic                        start = 1'b0;
    logic                        abort = 1'b0;
    logic [3:0]                  slot = 4'd0;
    logic [REGIONS-1:0]          region_en = '0;
    logic [24*REGIONS-1:0]       region_offset = '0;
    logic [A_BITS*REGIONS-1:0]   region_dest = '0;
    logic [LEN_BITS*REGIONS-1:0] region_len = '0;
    logic                        wr_busy = 1'b0;
    logic                        busy, done, aborted;
    logic [2:0]                  region_idx;
    logic [7:0]                  checksum;

    spi_flash_multiload_if #(.A_BITS(A_BITS)) bus();

    spi_flash_multiload #(
        .A_BITS(A_BITS), .LEN_BITS(LEN_BITS), .REGIONS(REGIONS),
        .SLOT_SHIFT(20), .CS_IDLE_TICKS(4)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .slot(slot),
        .region_en(region_en), .region_offset(region_offset),
        .region_dest(region_dest), .region_len(region_len), .bus(bus),
        .busy(busy), .done(done), .aborted(aborted),
        .region_idx(region_idx), .checksum(checksum)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Flash: unlisted addresses read back as addr[7:0] ^ 0x5A.
    logic [7:0] mem [int];
    logic       ack = 1'b0;
    logic [7:0] q = 8'h00;
    int         lat = 0;
    int         pos = 0;
    logic [23:0] faddr = '0;

    assign bus.spi_ack = ack;
    assign bus.spi_q   = q;
    assign bus.wr_busy = wr_busy;

    function automatic logic [7:0] rd(input logic [23:0] a);
        logic [7:0] lo;
        lo = a[7:0];
        return mem.exists(int'(a)) ? mem[int'(a)] : (lo ^ 8'h5A);
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            ack <= 1'b0;
            lat <= 0;
            pos <= 0;
        end else begin
            if (bus.cs_n) pos <= 0;
            if (bus.spi_req != ack) begin
                if (lat == 2) begin
                    lat <= 0;
                    ack <= bus.spi_req;
                    pos <= pos + 1;
                    if (pos == 1) faddr[23:16] <= bus.spi_d;
                    if (pos == 2) faddr[15:8]  <= bus.spi_d;
                    if (pos == 3) faddr[7:0]   <= bus.spi_d;
                    if (pos >= 4) begin
                        q     <= rd(faddr);
                        faddr <= faddr + 24'd1;
                    end else begin
                        q <= 8'hEE;
                    end
                end else begin
                    lat <= lat + 1;
                end
            end
        end
    end

    logic [7:0]  spi_log [$];
    logic [31:0] wq [$];
    int          hi_q [$];
    int          hi_run = 0;
    logic        prev_req = 1'b0;
    logic        prev_cs = 1'b1;

    always @(negedge clk) begin
        if (bus.spi_req !== prev_req) spi_log.push_back(bus.spi_d);
        if (bus.wr_strobe === 1'b1) wq.push_back(32'({bus.wr_a, bus.wr_d}));
        if (bus.cs_n === 1'b0 && prev_cs === 1'b1) hi_q.push_back(hi_run);
        hi_run   <= (bus.cs_n === 1'b1) ? hi_run + 1 : 0;
        prev_req <= bus.spi_req;
        prev_cs  <= bus.cs_n;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_wr(input int k, input logic [A_BITS-1:0] a, input logic [7:0] d);
        check($sformatf("wr%0d", k), (k < wq.size()) ? wq[k] : 32'hFFFF_FFFF, 32'({a, d}));
    endtask

    task automatic set_region(input int i, input logic en, input logic [23:0] off,
                              input logic [A_BITS-1:0] dst, input logic [LEN_BITS-1:0] len);
        region_en[i] = en;
        region_offset[24*i +: 24] = off;
        region_dest[A_BITS*i +: A_BITS] = dst;
        region_len[LEN_BITS*i +: LEN_BITS] = len;
    endtask

    task automatic clear_logs();
        spi_log.delete();
        wq.delete();
        hi_q.delete();
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 3000 && busy; i++) @(negedge clk);
        check({tag, "_idle"}, busy, 1'b0);
    endtask

    logic [7:0] exp_spi [8];
    int         n_before;

    initial begin
        mem[32'h200100] = 8'h11;
        mem[32'h200101] = 8'h22;
        mem[32'h200102] = 8'h33;
        mem[32'h200103] = 8'h44;

        repeat (3) @(negedge clk);
        check("rst_cs_n", bus.cs_n, 1'b1);
        check("rst_req", bus.spi_req, 1'b0);
        check("rst_spi_d", bus.spi_d, 8'h00);
        check("rst_strobe", bus.wr_strobe, 1'b0);
        check("rst_wr_a", bus.wr_a, '0);
        check("rst_wr_d", bus.wr_d, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_aborted", aborted, 1'b0);
        check("rst_ridx", region_idx, 3'd0);
        check("rst_csum", checksum, 8'h00);
        reset = 1'b0;
        @(negedge clk);

        // Single region, with a second start while busy that must be ignored.
        slot = 4'd2;
        set_region(0, 1'b1, 24'h000100, 14'h2000, 16'd4);
        clear_logs();
        pulse_start();
        check("t1_busy", busy, 1'b1);
        repeat (10) @(negedge clk);
        pulse_start();
        wait_idle("t1");
        exp_spi = '{8'h03, 8'h20, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        check("t1_nspi", spi_log.size(), 8);
        for (int i = 0; i < 8; i++)
            check($sformatf("t1_spi%0d", i), (i < spi_log.size()) ? spi_log[i] : 8'hxx, exp_spi[i]);
        check("t1_nwr", wq.size(), 4);
        check_wr(0, 14'h2000, 8'h11);
        check_wr(1, 14'h2001, 8'h22);
        check_wr(2, 14'h2002, 8'h33);
        check_wr(3, 14'h2003, 8'h44);
        check("t1_csum", checksum, 8'hAA);
        check("t1_done", done, 1'b1);
        check("t1_ntx", hi_q.size(), 1);
        check("t1_cs_n", bus.cs_n, 1'b1);

        // Region 1 disabled, region 2 zero length.
        slot = 4'd0;
        set_region(0, 1'b1, 24'h000010, 14'h0100, 16'd2);
        set_region(1, 1'b0, 24'h000050, 14'h0500, 16'd3);
        set_region(2, 1'b1, 24'h000060, 14'h0600, 16'd0);
        set_region(3, 1'b1, 24'h000020, 14'h0200, 16'd3);
        clear_logs();
        pulse_start();
        wait_idle("t2");
        check("t2_ntx", hi_q.size(), 2);
        check("t2_gap", (hi_q.size() > 1) ? 32'(hi_q[1] >= 4) : 32'd0, 32'd1);
        check("t2_nwr", wq.size(), 5);
        check_wr(0, 14'h0100, 8'h4A);
        check_wr(1, 14'h0101, 8'h4B);
        check_wr(2, 14'h0200, 8'h7A);
        check_wr(4, 14'h0202, 8'h78);
        check("t2_csum", checksum, 8'h02);
        check("t2_ridx", region_idx, 3'd4);
        check("t2_done", done, 1'b1);

        // Back-pressure on the second byte.
        region_en = '0;
        set_region(0, 1'b1, 24'h000040, 14'h0300, 16'd3);
        clear_logs();
        pulse_start();
        for (int i = 0; i < 200 && wq.size() < 1; i++) @(negedge clk);
        check("t3_first", wq.size(), 1);
        wr_busy = 1'b1;
        n_before = spi_log.size();
        repeat (16) @(negedge clk);
        check("t3_hold_req", spi_log.size(), n_before);
        check("t3_hold_wr", wq.size(), 1);
        wr_busy = 1'b0;
        wait_idle("t3");
        check("t3_nwr", wq.size(), 3);
        check_wr(0, 14'h0300, 8'h1A);
        check_wr(1, 14'h0301, 8'h1B);
        check_wr(2, 14'h0302, 8'h18);

        // Abort while the ADDR1 byte is outstanding, then restart.
        slot = 4'd2;
        set_region(0, 1'b1, 24'h000100, 14'h2000, 16'd4);
        clear_logs();
        pulse_start();
        for (int i = 0; i < 200 && spi_log.size() < 3; i++) @(negedge clk);
        check("t4_at_addr1", spi_log.size(), 3);
        abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        wait_idle("t4");
        check("t4_aborted", aborted, 1'b1);
        check("t4_done", done, 1'b0);
        check("t4_cs_n", bus.cs_n, 1'b1);
        check("t4_nwr", wq.size(), 0);
        check("t4_nspi", spi_log.size(), 3);
        check("t4_acked", bus.spi_ack, bus.spi_req);
        clear_logs();
        pulse_start();
        wait_idle("t4b");
        check("t4b_done", done, 1'b1);
        check("t4b_aborted", aborted, 1'b0);
        check("t4b_nwr", wq.size(), 4);
        check("t4b_csum", checksum, 8'hAA);

        // Destination wrap.
        slot = 4'd0;
        set_region(0, 1'b1, 24'h000080, 14'h3FFE, 16'd4);
        clear_logs();
        pulse_start();
        wait_idle("t5");
        check_wr(0, 14'h3FFE, 8'hDA);
        check_wr(1, 14'h3FFF, 8'hDB);
        check_wr(2, 14'h0000, 8'hD8);
        check_wr(3, 14'h0001, 8'hD9);

        // Synchronous reset in the middle of the data phase.
        clear_logs();
        pulse_start();
        for (int i = 0; i < 200 && wq.size() < 1; i++) @(negedge clk);
        check("t6_first", wq.size(), 1);
        reset = 1'b1;
        @(negedge clk);
        check("t6_cs_n", bus.cs_n, 1'b1);
        check("t6_busy", busy, 1'b0);
        check("t6_req", bus.spi_req, 1'b0);
        check("t6_strobe", bus.wr_strobe, 1'b0);
        check("t6_csum", checksum, 8'h00);
        check("t6_ridx", region_idx, 3'd0);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        check("t6_nwr", wq.size(), 1);
        check("t6_idle", busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
